// File: rtl/ss_pkg.sv
// Shared store-size encodings and FSM state type for the store merge unit.
// The ss_control encoding matches the one used by the control unit and the
// load-size unit, so all three agree on what 00/01/10/11 mean.
package ss_pkg;

    localparam logic [1:0] SS_SB  = 2'b00;
    localparam logic [1:0] SS_SH  = 2'b01;
    localparam logic [1:0] SS_SW  = 2'b10;
    localparam logic [1:0] SS_INV = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } ss_state_t;

    // A store is rejected when its size is invalid or its address is not
    // naturally aligned for that size; such stores never touch memory.
    function automatic logic ss_is_err(input logic [1:0] size, input logic [1:0] lane);
        logic err;
        err = 1'b0;
        case (size)
            SS_SH:   err = lane[0];
            SS_SW:   err = (lane != 2'b00);
            SS_INV:  err = 1'b1;
            default: err = 1'b0;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: inserts the low byte or halfword of the store
// data into the addressed little-endian lane of the old word, leaving every
// other lane bit-exact. Word stores replace the whole word.
module store_lane_merge
    import ss_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] store_data,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    output logic [31:0] merged
);

    // Start from the read-back word and overwrite only the selected lane.
    always_comb begin
        merged = old_word;
        case (size)
            SS_SB: begin
                case (lane)
                    2'd0:    merged[7:0]   = store_data[7:0];
                    2'd1:    merged[15:8]  = store_data[7:0];
                    2'd2:    merged[23:16] = store_data[7:0];
                    default: merged[31:24] = store_data[7:0];
                endcase
            end
            SS_SH: begin
                if (lane[1]) begin
                    merged[31:16] = store_data[15:0];
                end else begin
                    merged[15:0] = store_data[15:0];
                end
            end
            SS_SW:   merged = store_data;
            default: merged = old_word;
        endcase
    end

endmodule

// File: rtl/store_merge_unit.sv
// Store unit for a single-port word-addressed data memory. Word stores go
// straight to a write; byte and halfword stores read the containing word,
// merge the new lane in, and write the word back. Misaligned or invalid
// stores finish immediately with store_err and never access memory.
module store_merge_unit
    import ss_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  ss_control,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr,
    output logic        busy,
    output logic        done,
    output logic        store_err
);

    ss_state_t   state_q, state_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] data_q,  data_d;
    logic [1:0]  size_q,  size_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q,   err_d;
    logic        start_err;
    logic [31:0] merged_word;

    assign start_err = ss_is_err(ss_control, address[1:0]);

    store_lane_merge u_merge (
        .old_word   (rdata_q),
        .store_data (data_q),
        .size       (size_q),
        .lane       (addr_q[1:0]),
        .merged     (merged_word)
    );

    // Next-state logic; request fields are latched only when a start is accepted in IDLE.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        size_d  = size_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d = address;
                    data_d = store_data;
                    size_d = ss_control;
                    err_d  = start_err;
                    if (start_err) begin
                        state_d = DONE;
                    end else if (ss_control == SS_SW) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ:  state_d = WAIT;
            WAIT: begin
                rdata_d = mem_rdata;
                state_d = WRITE;
            end
            WRITE: state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and request registers; reset abandons any store in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            size_q  <= SS_SB;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            size_q  <= size_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = merged_word;
    assign mem_wr    = (state_q == WRITE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign store_err = err_q;

endmodule

// File: doc/store_merge_unit.md
# store_merge_unit

Store-side counterpart of the load-size unit: performs `sb`/`sh`/`sw` stores to the single-port, word-addressed data memory. Sub-word stores use a read-modify-write sequence: read the containing word, merge the selected byte or halfword lanes, write the word back. Sits between the control unit (start/done handshake), the datapath (address from ALUOut, data from register B) and the memory port.

## Interface
Parameters:
- none (widths fixed at 32 bits)

Ports:
- `clk`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request pulse from control unit; accepted only in IDLE
- `ss_control`  in  2  store size: 00 sb, 01 sh, 10 sw, 11 invalid
- `address`  in  32  byte address of the store
- `store_data`  in  32  source register value; byte/half taken from low bits
- `mem_rdata`  in  32  memory read data, valid the cycle after `mem_addr` is presented with `mem_wr`=0
- `mem_addr`  out  32  word-aligned address, `{addr_q[31:2],2'b00}`
- `mem_wdata`  out  32  merged write word
- `mem_wr`  out  1  write strobe, exactly one cycle per successful store
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse
- `store_err`  out  1  valid with `done`; held until next accepted `start`

## Operation
- On accepted `start`: latch `ss_control`, `address`, `store_data` into internal registers; later input changes are ignored until completion.
- Little-endian lanes: byte lane = `addr_q[1:0]` (lane 0 = bits 7:0); halfword lane = `addr_q[1]` (0 → bits 15:0, 1 → bits 31:16).
- Error conditions (no memory access, `mem_wr` never asserted): `sh` with `addr_q[0]`=1; `sw` with `addr_q[1:0]`≠0; `ss_control`=11.
- States:
  - IDLE: `start` & error → DONE (err); `start` & sw → WRITE; `start` & sb/sh → READ; else stay.
  - READ: present `mem_addr`, `mem_wr`=0 → WAIT.
  - WAIT: capture `mem_rdata` into the merge register → WRITE.
  - WRITE: `mem_wr`=1, `mem_wdata` = merged word (sw: `store_data` unchanged) → DONE.
  - DONE: `done`=1 → IDLE.
- Merge: untouched lanes keep read-back bits exactly; written lane receives `store_data[7:0]` or `store_data[15:0]`.
- `start` while busy: ignored, with no queueing. `start` in DONE is also ignored; it must be re-issued once IDLE is reached.

## Timing
- Reset (async assert): state IDLE. All outputs 0: `mem_addr`, `mem_wdata`, `mem_wr`, `busy`, `done`, `store_err`. Internal registers are cleared.
- Reset mid-operation: `mem_wr` drops immediately. No partial write completes, and no `done` is produced.
- Latency (`start` sampled at edge T):
  - sw: write cycle T+1, `done` T+2.
  - sb/sh: read cycle T+1, capture T+2, write T+3, `done` T+4.
  - error: `done`+`store_err` at T+1.
- `busy` rises the cycle after the `start` edge and falls when IDLE is re-entered.
- `mem_addr` is stable from READ through WRITE.
- All outputs are registered or derived from state only; no combinational path from inputs to outputs.

## Structure
- Shared package `ss_pkg` holds:
  - `ss_control` encodings `SS_SB`, `SS_SH`, `SS_SW`, `SS_INV`, shared with the control unit and the load-size unit encoding;
  - state enum `ss_state_t` (IDLE, READ, WAIT, WRITE, DONE).
- Sub-module `store_lane_merge`: purely combinational.
  - inputs: old word, store data, size, `addr[1:0]`
  - output: merged word
  - reused by the bench as the reference model.

## Test plan
- sw aligned: `address`=0x100, `store_data`=0xDEADBEEF → `mem_wr` at T+1 with `mem_addr`=0x100, `mem_wdata`=0xDEADBEEF; `done` at T+2, `store_err`=0.
- sb all lanes: memory word 0x11223344 at 0x200, `store_data`=0xAA, `address`=0x200..0x203 → writes 0x112233AA, 0x1122AA44, 0x11AA3344, 0xAA223344; `done` at T+4 each.
- sh upper half: memory 0xCAFEBABE at 0x40, `address`=0x42, `store_data`=0x12345678 → write 0x5678BABE.
- Misaligned / invalid: sh at 0x41, sw at 0x46, `ss_control`=11 → `mem_wr` never asserted; `done`=`store_err`=1 at T+1; memory unchanged.
- Busy handling: second `start` (sw 0x300) during an sb in WAIT → ignored, exactly one write; input changes after T do not alter the write.
- Reset in WAIT: `reset_n` low → `mem_wr`, `busy` and `done` go low immediately; state IDLE; memory unchanged; a following sw completes normally.
